alu_sequencer: RTL and testbench

Front-end controller for the 8-bit ALU (op[3:0], A, B, CarryBit, Decimal -> Result, PSRout). It accepts one ALU operation at a time from the instruction decoder over a valid/ready handshake and drives the ALU inputs for the ALU's clocked latency. It then captures Result/PSRout, merges only the flags that the op legally affects into the processor status, and hands the result to the register/memory writeback path.

---
 rtl/alu_seq_pkg.sv | 63 ++++++
 rtl/alu_sequencer_if.sv | 44 ++++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared opcodes, status-bit indices, writeback destination
//                codes, sequencer state encoding and per-op flag masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_OP_W   = 4;
    localparam int c_PSR_W  = 8;
    localparam int c_DEST_W = 2;
    localparam int c_CNT_W  = 2;   // covers ALU_LAT 1..4

    // ALU opcodes; 11xx is reserved and treated as illegal
    localparam logic [c_OP_W-1:0] c_OP_ADC = 4'b0000;
    localparam logic [c_OP_W-1:0] c_OP_SBC = 4'b0001;
    localparam logic [c_OP_W-1:0] c_OP_AND = 4'b0010;
    localparam logic [c_OP_W-1:0] c_OP_OR  = 4'b0011;
    localparam logic [c_OP_W-1:0] c_OP_XOR = 4'b0100;
    localparam logic [c_OP_W-1:0] c_OP_CMP = 4'b0101;
    localparam logic [c_OP_W-1:0] c_OP_INC = 4'b0110;
    localparam logic [c_OP_W-1:0] c_OP_DEC = 4'b0111;
    localparam logic [c_OP_W-1:0] c_OP_ASL = 4'b1000;
    localparam logic [c_OP_W-1:0] c_OP_LSR = 4'b1001;
    localparam logic [c_OP_W-1:0] c_OP_ROR = 4'b1010;
    localparam logic [c_OP_W-1:0] c_OP_ROL = 4'b1011;

    // Processor status bit positions (N V - B D I Z C)
    localparam int c_PSR_C = 0;
    localparam int c_PSR_Z = 1;
    localparam int c_PSR_I = 2;
    localparam int c_PSR_D = 3;
    localparam int c_PSR_B = 4;
    localparam int c_PSR_V = 6;
    localparam int c_PSR_N = 7;

    // Writeback destinations
    localparam logic [c_DEST_W-1:0] c_DEST_A   = 2'b00;
    localparam logic [c_DEST_W-1:0] c_DEST_X   = 2'b01;
    localparam logic [c_DEST_W-1:0] c_DEST_Y   = 2'b10;
    localparam logic [c_DEST_W-1:0] c_DEST_MEM = 2'b11;

    // Flags each op class is allowed to update
    localparam logic [c_PSR_W-1:0] c_MASK_NVZC = 8'hC3;
    localparam logic [c_PSR_W-1:0] c_MASK_NZ   = 8'h82;
    localparam logic [c_PSR_W-1:0] c_MASK_NZC  = 8'h83;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Source of the ALU carry input
    typedef enum logic [1:0] {
        CSEL_ZERO = 2'd0,
        CSEL_ONE  = 2'd1,
        CSEL_REQ  = 2'd2
    } carry_sel_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Request (decoder -> sequencer) and writeback
//                (sequencer -> register/memory path) handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int W = 8
) ();
    import alu_seq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [c_OP_W-1:0]   req_op;
    logic [W-1:0]        req_a;
    logic [W-1:0]        req_b;
    logic                req_carry;
    logic                req_decimal;
    logic [c_DEST_W-1:0] req_dest;

    logic                wb_valid;
    logic                wb_ready;
    logic [c_DEST_W-1:0] wb_dest;
    logic [W-1:0]        wb_data;

    // Requester / writeback-sink side
    modport master (
        output req_valid, req_op, req_a, req_b, req_carry, req_decimal, req_dest,
        input  req_ready,
        input  wb_valid, wb_dest, wb_data,
        output wb_ready
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_carry, req_decimal, req_dest,
        output req_ready,
        output wb_valid, wb_dest, wb_data,
        input  wb_ready
    );

endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational opcode classifier: flag mask, carry source,
//                decimal enable, flags-only (compare) and illegal detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  wire logic [c_OP_W-1:0]  i_op,
    output logic      [c_PSR_W-1:0] o_mask,
    output carry_sel_t              o_carry_sel,
    output logic                    o_decimal_en,
    output logic                    o_flags_only,
    output logic                    o_illegal
);

    // Classify the opcode; anything outside the defined set is illegal
    always_comb begin
        o_mask       = '0;
        o_carry_sel  = CSEL_ZERO;
        o_decimal_en = 1'b0;
        o_flags_only = 1'b0;
        o_illegal    = 1'b0;
        case (i_op)
            c_OP_ADC, c_OP_SBC: begin
                o_mask       = c_MASK_NVZC;
                o_carry_sel  = CSEL_REQ;
                o_decimal_en = 1'b1;
            end
            c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_INC, c_OP_DEC: begin
                o_mask = c_MASK_NZ;
            end
            c_OP_CMP: begin
                // Compare is a subtract with no incoming borrow
                o_mask       = c_MASK_NZC;
                o_carry_sel  = CSEL_ONE;
                o_flags_only = 1'b1;
            end
            c_OP_ASL, c_OP_LSR: begin
                o_mask = c_MASK_NZC;
            end
            c_OP_ROR, c_OP_ROL: begin
                o_mask      = c_MASK_NZC;
                o_carry_sel = CSEL_REQ;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Issues one operation at a time to a clocked 8-bit ALU,
//                waits out its latency, merges the legally affected flags
//                into the status word and hands the result to writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1,   // 1..4
    parameter int W       = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    alu_sequencer_if.slave           bus,
    input  wire logic [c_PSR_W-1:0]  psr_in,
    output logic      [W-1:0]        alu_a,
    output logic      [W-1:0]        alu_b,
    output logic                     alu_carry,
    output logic      [c_OP_W-1:0]   alu_op,
    output logic                     alu_decimal,
    input  wire logic [W-1:0]        alu_result,
    input  wire logic [c_PSR_W-1:0]  alu_psr,
    output logic                     psr_we,
    output logic      [c_PSR_W-1:0]  psr_out,
    output logic                     err,
    output logic                     busy
);

    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(ALU_LAT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [W-1:0]         r_alu_a;
    logic [W-1:0]         r_alu_b;
    logic                 r_alu_carry;
    logic [c_OP_W-1:0]    r_alu_op;
    logic                 r_alu_decimal;
    logic [c_DEST_W-1:0]  r_dest;
    logic [c_PSR_W-1:0]   r_mask;
    logic                 r_flags_only;
    logic                 r_psr_we;
    logic [c_PSR_W-1:0]   r_psr_out;
    logic                 r_wb_valid;
    logic [W-1:0]         r_wb_data;
    logic                 r_err;

    logic [c_PSR_W-1:0]   w_mask;
    carry_sel_t           w_carry_sel;
    logic                 w_decimal_en;
    logic                 w_flags_only;
    logic                 w_illegal;
    logic                 w_carry;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_wb_hs;
    logic [c_PSR_W-1:0]   w_psr_merge;

    alu_op_decode u_decode (
        .i_op         (bus.req_op),
        .o_mask       (w_mask),
        .o_carry_sel  (w_carry_sel),
        .o_decimal_en (w_decimal_en),
        .o_flags_only (w_flags_only),
        .o_illegal    (w_illegal)
    );

    // Carry presented to the ALU for the incoming request
    always_comb begin
        w_carry = 1'b0;
        case (w_carry_sel)
            CSEL_ONE: w_carry = 1'b1;
            CSEL_REQ: w_carry = bus.req_carry;
            default:  w_carry = 1'b0;
        endcase
    end

    // Only the flags the op may touch come from the ALU; the rest pass through
    assign w_psr_merge = (psr_in & ~r_mask) | (alu_psr & r_mask);

    // Next-state logic and the accept/capture/handshake strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_wb_hs      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.req_valid;
                if (bus.req_valid && !w_illegal) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_flags_only) begin
                    w_next_state = ST_IDLE;
                end else if (r_wb_valid && bus.wb_ready) begin
                    w_wb_hs      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latency counter: loaded on accept, counts down while issuing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept && !w_illegal) begin
            r_cnt <= c_LAT_M1;
        end else if (r_state == ST_ISSUE && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // ALU operand registers, held from accept until the next legal accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_carry   <= 1'b0;
            r_alu_op      <= '0;
            r_alu_decimal <= 1'b0;
            r_dest        <= '0;
            r_mask        <= '0;
            r_flags_only  <= 1'b0;
        end else if (w_accept && !w_illegal) begin
            r_alu_a       <= bus.req_a;
            r_alu_b       <= bus.req_b;
            r_alu_carry   <= w_carry;
            r_alu_op      <= bus.req_op;
            r_alu_decimal <= bus.req_decimal & w_decimal_en;
            r_dest        <= bus.req_dest;
            r_mask        <= w_mask;
            r_flags_only  <= w_flags_only;
        end
    end

    // Result capture, status strobe, writeback valid and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_psr_we   <= 1'b0;
            r_psr_out  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_psr_we <= w_capture;
            r_err    <= w_accept & w_illegal;
            if (w_capture) begin
                r_wb_data  <= alu_result;
                r_psr_out  <= w_psr_merge;
                r_wb_valid <= ~r_flags_only;
            end else if (w_wb_hs) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_dest   = r_dest;
    assign bus.wb_data   = r_wb_data;

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_carry   = r_alu_carry;
    assign alu_op      = r_alu_op;
    assign alu_decimal = r_alu_decimal;
    assign psr_we      = r_psr_we;
    assign psr_out     = r_psr_out;
    assign err         = r_err;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench: table of single operations on an
//                ALU_LAT=1 instance, backpressure and illegal-op sequences,
//                and a reset-abort sequence on an ALU_LAT=3 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       d;
        logic [1:0] dest;
        logic [7:0] psr_in;
        logic       exp_carry;
        logic       exp_dec;
        logic [7:0] exp_data;
        logic [7:0] exp_psr;
        logic       exp_wb;
    } vec_t;

    logic clk = 1'b0;
    logic reset1, reset3;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] psr_q1[$];
    logic [9:0] wb_q1[$];
    logic [7:0] psr_q3[$];
    logic [9:0] wb_q3[$];

    alu_sequencer_if #(.W(8)) bus1 ();
    alu_sequencer_if #(.W(8)) bus3 ();

    logic [7:0] psr_in1, psr_in3;
    logic [7:0] alu_a1, alu_b1, alu_res1, alu_psr1, psr_out1;
    logic [7:0] alu_a3, alu_b3, alu_res3, alu_psr3, psr_out3;
    logic [3:0] alu_op1, alu_op3;
    logic       alu_c1, alu_d1, psr_we1, err1, busy1;
    logic       alu_c3, alu_d3, psr_we3, err3, busy3;

    // Reference ALU: binary arithmetic; status bits outside the op's legal
    // flag set are deliberately driven to 1 so a wrong mask shows up.
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic c);
        logic [8:0] s;
        logic [7:0] r, bb;
        logic       v, cf;
        s = '0; r = '0; bb = b; v = 1'b1; cf = 1'b1;
        case (op)
            4'h0, 4'h1, 4'h5: begin
                bb = (op == 4'h0) ? b : ~b;
                s  = {1'b0, a} + {1'b0, bb} + {8'h00, c};
                r  = s[7:0];
                cf = s[8];
                v  = (op == 4'h5) ? 1'b1 : ((a[7] == bb[7]) && (r[7] != a[7]));
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h6: r = a + 8'd1;
            4'h7: r = a - 8'd1;
            4'h8: begin r = {a[6:0], 1'b0}; cf = a[7]; end
            4'h9: begin r = {1'b0, a[7:1]}; cf = a[0]; end
            4'hA: begin r = {c, a[7:1]};    cf = a[0]; end
            4'hB: begin r = {a[6:0], c};    cf = a[7]; end
            default: r = 8'h00;
        endcase
        return {r[7], v, 4'b1111, (r == 8'h00), cf, r};
    endfunction

    assign {alu_psr1, alu_res1} = alu_model(alu_op1, alu_a1, alu_b1, alu_c1);
    assign {alu_psr3, alu_res3} = alu_model(alu_op3, alu_a3, alu_b3, alu_c3);

    alu_sequencer #(.ALU_LAT(1), .W(8)) dut1 (
        .clk(clk), .reset(reset1), .bus(bus1), .psr_in(psr_in1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_carry(alu_c1), .alu_op(alu_op1),
        .alu_decimal(alu_d1), .alu_result(alu_res1), .alu_psr(alu_psr1),
        .psr_we(psr_we1), .psr_out(psr_out1), .err(err1), .busy(busy1)
    );

    alu_sequencer #(.ALU_LAT(3), .W(8)) dut3 (
        .clk(clk), .reset(reset3), .bus(bus3), .psr_in(psr_in3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_carry(alu_c3), .alu_op(alu_op3),
        .alu_decimal(alu_d3), .alu_result(alu_res3), .alu_psr(alu_psr3),
        .psr_we(psr_we3), .psr_out(psr_out3), .err(err3), .busy(busy3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the ALU_LAT=1 instance
    always @(negedge clk) begin
        #1;
        if (psr_we1) begin
            chk("psr1_expected", (psr_q1.size() != 0), 1);
            if (psr_q1.size() != 0) chk("psr1_out", psr_out1, psr_q1.pop_front());
        end
        if (bus1.wb_valid && bus1.wb_ready) begin
            chk("wb1_expected", (wb_q1.size() != 0), 1);
            if (wb_q1.size() != 0) chk("wb1_dest_data", {bus1.wb_dest, bus1.wb_data}, wb_q1.pop_front());
        end
    end

    // Scoreboard for the ALU_LAT=3 instance
    always @(negedge clk) begin
        #1;
        if (psr_we3) begin
            chk("psr3_expected", (psr_q3.size() != 0), 1);
            if (psr_q3.size() != 0) chk("psr3_out", psr_out3, psr_q3.pop_front());
        end
        if (bus3.wb_valid && bus3.wb_ready) begin
            chk("wb3_expected", (wb_q3.size() != 0), 1);
            if (wb_q3.size() != 0) chk("wb3_dest_data", {bus3.wb_dest, bus3.wb_data}, wb_q3.pop_front());
        end
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic c, input logic d, input logic [1:0] dest,
                                input logic [7:0] pin, input logic ec, input logic ed,
                                input logic [7:0] edata, input logic [7:0] epsr, input logic ewb);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.d = d; v.dest = dest; v.psr_in = pin;
        v.exp_carry = ec; v.exp_dec = ed; v.exp_data = edata; v.exp_psr = epsr; v.exp_wb = ewb;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        chk($sformatf("v%0d_ready_before", idx), bus1.req_ready, 1);
        bus1.req_op = v.op; bus1.req_a = v.a; bus1.req_b = v.b;
        bus1.req_carry = v.c; bus1.req_decimal = v.d; bus1.req_dest = v.dest;
        bus1.req_valid = 1'b1;
        psr_in1 = v.psr_in;
        psr_q1.push_back(v.exp_psr);
        if (v.exp_wb) wb_q1.push_back({v.dest, v.exp_data});
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk($sformatf("v%0d_alu_op", idx), alu_op1, v.op);
        chk($sformatf("v%0d_alu_a", idx), alu_a1, v.a);
        chk($sformatf("v%0d_alu_carry", idx), alu_c1, v.exp_carry);
        chk($sformatf("v%0d_alu_decimal", idx), alu_d1, v.exp_dec);
        chk($sformatf("v%0d_busy", idx), busy1, 1);
        n = 1;
        while (!bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_ready_latency", idx), n, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        int   n;
        int   cnt;

        vecs[0]  = mk(c_OP_ADC, 8'h7F, 8'h01, 0, 0, 2'd1, 8'h24, 0, 0, 8'h80, 8'hE4, 1);
        vecs[1]  = mk(c_OP_CMP, 8'h10, 8'h08, 0, 1, 2'd0, 8'h00, 1, 0, 8'h08, 8'h01, 0);
        vecs[2]  = mk(c_OP_AND, 8'hF0, 8'h3C, 1, 1, 2'd2, 8'hFF, 0, 0, 8'h30, 8'h7D, 1);
        vecs[3]  = mk(c_OP_ROL, 8'h89, 8'h00, 1, 0, 2'd3, 8'h00, 1, 0, 8'h13, 8'h01, 1);
        vecs[4]  = mk(c_OP_SBC, 8'h50, 8'h70, 1, 0, 2'd0, 8'hC3, 1, 0, 8'hE0, 8'h80, 1);
        vecs[5]  = mk(c_OP_ADC, 8'h12, 8'h34, 0, 1, 2'd1, 8'hFF, 0, 1, 8'h46, 8'h3C, 1);
        vecs[6]  = mk(c_OP_XOR, 8'hAA, 8'hAA, 1, 0, 2'd2, 8'h80, 0, 0, 8'h00, 8'h02, 1);
        vecs[7]  = mk(c_OP_INC, 8'hFF, 8'h00, 1, 1, 2'd3, 8'h01, 0, 0, 8'h00, 8'h03, 1);
        vecs[8]  = mk(c_OP_DEC, 8'h00, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h80, 1);
        vecs[9]  = mk(c_OP_ASL, 8'hC0, 8'h00, 1, 0, 2'd1, 8'h40, 0, 0, 8'h80, 8'hC1, 1);
        vecs[10] = mk(c_OP_LSR, 8'h01, 8'h00, 0, 0, 2'd2, 8'h80, 0, 0, 8'h00, 8'h03, 1);
        vecs[11] = mk(c_OP_ROR, 8'h02, 8'h00, 1, 0, 2'd3, 8'h01, 1, 0, 8'h81, 8'h80, 1);

        reset1 = 1'b1; reset3 = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_op = '0; bus1.req_a = '0; bus1.req_b = '0;
        bus1.req_carry = 1'b0; bus1.req_decimal = 1'b0; bus1.req_dest = '0; bus1.wb_ready = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_op = '0; bus3.req_a = '0; bus3.req_b = '0;
        bus3.req_carry = 1'b0; bus3.req_decimal = 1'b0; bus3.req_dest = '0; bus3.wb_ready = 1'b1;
        psr_in1 = 8'h00; psr_in3 = 8'h00;

        repeat (3) @(negedge clk);
        reset1 = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus1.req_ready, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_alu_op", alu_op1, 0);
        chk("rst_alu_a", alu_a1, 0);
        chk("rst_psr_out", psr_out1, 0);
        chk("rst_wb_valid", bus1.wb_valid, 0);
        chk("rst_err", err1, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Writeback backpressure with a second request held pending
        @(negedge clk);
        bus1.wb_ready = 1'b0;
        bus1.req_op = c_OP_OR; bus1.req_a = 8'hAA; bus1.req_b = 8'h55;
        bus1.req_carry = 1'b1; bus1.req_decimal = 1'b0; bus1.req_dest = 2'd2;
        bus1.req_valid = 1'b1;
        psr_in1 = 8'h00;
        psr_q1.push_back(8'h80);
        wb_q1.push_back({2'd2, 8'hFF});
        @(negedge clk);
        bus1.req_op = c_OP_XOR; bus1.req_a = 8'h0F; bus1.req_b = 8'hFF; bus1.req_dest = 2'd1;
        psr_q1.push_back(8'h80);
        wb_q1.push_back({2'd1, 8'hF0});
        n = 0;
        while (!bus1.wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wb_seen", bus1.wb_valid, 1);
        cnt = 0;
        while (bus1.wb_valid && cnt < 10) begin
            cnt++;
            chk("bp_data_stable", {bus1.wb_dest, bus1.wb_data}, {2'd2, 8'hFF});
            chk("bp_req_blocked", bus1.req_ready, 0);
            chk("bp_alu_op_held", alu_op1, c_OP_OR);
            if (cnt == 4) bus1.wb_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_valid_cycles", cnt, 4);
        chk("bp_ready_after_hs", bus1.req_ready, 1);
        chk("bp_not_yet_accepted", alu_op1, c_OP_OR);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk("bp_second_accepted", alu_op1, c_OP_XOR);
        n = 0;
        while (!bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_done", bus1.req_ready, 1);

        // Illegal opcode: error pulse only
        @(negedge clk);
        bus1.req_op = 4'b1101; bus1.req_valid = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk("ill_err", err1, 1);
        chk("ill_alu_op_kept", alu_op1, c_OP_XOR);
        chk("ill_req_ready", bus1.req_ready, 1);
        chk("ill_busy", busy1, 0);
        chk("ill_psr_we", psr_we1, 0);
        chk("ill_wb_valid", bus1.wb_valid, 0);
        @(negedge clk);
        chk("ill_err_single", err1, 0);

        // ALU_LAT=3: normal operation latency
        @(negedge clk);
        bus3.req_op = c_OP_ADC; bus3.req_a = 8'h7F; bus3.req_b = 8'h01;
        bus3.req_carry = 1'b0; bus3.req_dest = 2'd3; bus3.req_valid = 1'b1;
        psr_in3 = 8'h24;
        psr_q3.push_back(8'hE4);
        wb_q3.push_back({2'd3, 8'h80});
        @(negedge clk);
        bus3.req_valid = 1'b0;
        n = 1;
        while (!bus3.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_ready_latency", n, 5);

        // ALU_LAT=3: reset in the second issue cycle aborts the op
        bus3.req_op = c_OP_OR; bus3.req_a = 8'h05; bus3.req_b = 8'h03; bus3.req_valid = 1'b1;
        @(negedge clk);
        bus3.req_valid = 1'b0;
        chk("abort_busy_issue", busy3, 1);
        @(negedge clk);
        reset3 = 1'b1;
        bus3.req_valid = 1'b1;
        @(negedge clk);
        chk("abort_idle", busy3, 0);
        chk("abort_req_ready", bus3.req_ready, 1);
        chk("abort_alu_a", alu_a3, 0);
        chk("abort_alu_op", alu_op3, 0);
        chk("abort_alu_carry", alu_c3, 0);
        chk("abort_psr_out", psr_out3, 0);
        chk("abort_wb_data", bus3.wb_data, 0);
        chk("abort_wb_valid", bus3.wb_valid, 0);
        chk("abort_psr_we", psr_we3, 0);
        @(negedge clk);
        chk("abort_no_accept_in_reset", busy3, 0);
        reset3 = 1'b0;
        bus3.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_still_idle", busy3, 0);

        @(negedge clk);
        chk("sb1_psr_drained", psr_q1.size(), 0);
        chk("sb1_wb_drained", wb_q1.size(), 0);
        chk("sb3_psr_drained", psr_q3.size(), 0);
        chk("sb3_wb_drained", wb_q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
